// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and
// a small sizing helper used by the receiver and its sibling blocks.
package uart_pkg;

  // Default bit period in core clocks; the transmitter and the clock divider
  // configuration use the same value.
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_rx_state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high line (UART Rx) or idle-low pin can be preset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state: a plain two-stage shift.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, preset to the line's idle level.
  // NOTE: sequential state is only ever assigned with <=, so every flop samples
  // the pre-edge value of its neighbours and the stages cannot collapse.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronises Rx, times each bit with a mid-bit sample,
// and hands completed bytes to the datapath through a one-deep holding
// register with sticky framing-error and overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 byte_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int CNT_W = count_width(CLKS_PER_BIT);
  localparam int IDX_W = count_width(DATA_BITS);

  // Sample points: half a bit into the start bit, then one full bit later
  // for every data bit and the stop bit (i.e. each bit's centre).
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic                 rx_s;

  uart_rx_state_t       state_q,      state_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [IDX_W-1:0]     idx_q,        idx_d;
  logic [DATA_BITS-1:0] shreg_q,      shreg_d;
  logic [DATA_BITS-1:0] rx_byte_q,    rx_byte_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 overrun_q,    overrun_d;

  // The line idles high, so the synchroniser comes out of reset at 1 and
  // cannot fake a start bit.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (Rx),
    .q     (rx_s)
  );

  // Next-state logic for the frame FSM, bit timing and the holding register.
  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = byte_valid_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    // Consumer side first; a commit or error below in the same cycle
    // overrides these, which gives "commit wins" and "error wins".
    if (rd_ack) begin
      byte_valid_d = 1'b0;
    end
    if (err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          // Line back high at mid start bit: a glitch, drop it silently.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s) begin
            rx_byte_d    = shreg_q;
            byte_valid_d = 1'b1;
            if (byte_valid_q && !rd_ack) begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CLEANUP: begin
        // Wait for the line to go high so a held-low break is not seen as
        // a stream of new start bits.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Shift register for the payload being assembled.
  // NOTE: deliberately left out of reset: every bit is rewritten during DATA
  // before it can reach rx_byte, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign rx_busy    = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a model transmitter drives Rx, and a
// frame-level reference model predicts the holding register and flags.
module tb_uart_receiver;

  localparam int C   = 8;
  localparam int DB  = 8;
  // Edges from the first edge that sees Rx low to the edge where byte_valid rises.
  localparam int LAT = 2 + C / 2 + (DB + 1) * C;
  localparam int FRAME_CYC = (DB + 2) * C;

  logic          clk = 1'b0;
  logic          reset;
  logic          Rx;
  logic          rd_ack;
  logic          err_clr;
  logic [DB-1:0] rx_byte;
  logic          byte_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state, updated per frame from the receiver's rules.
  logic [DB-1:0] exp_byte  = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ferr  = 1'b0;
  logic          exp_ovr   = 1'b0;

  uart_receiver #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rx         (Rx),
    .rd_ack     (rd_ack),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) tick();
  endtask

  // Model transmitter. Inputs set at step k act on edge k+1; edge 1 is the
  // first edge that sees the start bit. ack_k selects the step whose edge
  // carries an rd_ack pulse (-1 = none). rise_edge reports the edge at which
  // byte_valid went 0->1, or -1.
  task automatic drive_frame(input logic [DB-1:0] data, input logic stop,
                             input int ack_k, input int ncyc, output int rise_edge);
    logic prev;
    prev      = byte_valid;
    rise_edge = -1;
    for (int k = 0; k < ncyc; k++) begin
      int b;
      b = k / C;
      if (b == 0)       Rx = 1'b0;
      else if (b <= DB) Rx = data[b-1];
      else              Rx = stop;
      rd_ack = (k == ack_k);
      tick();
      if (byte_valid && !prev && rise_edge < 0) rise_edge = k + 1;
      prev = byte_valid;
    end
    rd_ack = 1'b0;
    Rx     = 1'b1;
  endtask

  // Frame-level reference: what one complete frame does to the visible state.
  function automatic void model_frame(input logic [DB-1:0] data, input logic stop,
                                      input int ack_k);
    if (ack_k >= 0 && ack_k < LAT) exp_valid = 1'b0;
    if (stop) begin
      if (exp_valid && ack_k != LAT) exp_ovr = 1'b1;
      exp_byte  = data;
      exp_valid = 1'b1;
      if (ack_k == LAT + 1) exp_valid = 1'b0;
    end else begin
      exp_ferr = 1'b1;
      if (ack_k == LAT || ack_k == LAT + 1) exp_valid = 1'b0;
    end
  endfunction

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    reset = 1'b0;
    idle(4);
    checks++; if (rx_busy !== 1'b0 || byte_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0", rx_busy, byte_valid); end
  endtask

  task automatic test_frame_a5();
    int rise;
    drive_frame(8'hA5, 1'b1, -1, FRAME_CYC, rise);
    model_frame(8'hA5, 1'b1, -1);
    checks++; if (rise !== 1 + LAT) begin errors++; $display("FAIL a5_latency: rose at edge %0d want %0d", rise, 1 + LAT); end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL a5_byte: got %h want a5", rx_byte); end
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL a5_valid: got %b want 1", byte_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b want 0", frame_err); end
    pulse_ack();
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL a5_ack_clears: got %b want 0", byte_valid); end
  endtask

  task automatic test_glitch();
    Rx = 1'b0;
    repeat (3) tick();
    Rx = 1'b1;
    repeat (2) tick();
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %b want 1", rx_busy); end
    idle(10);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: got %b want 0", rx_busy); end
    checks++; if ({byte_valid, frame_err, overrun} !== 3'b000) begin errors++; $display("FAIL glitch_flags: got %b want 000", {byte_valid, frame_err, overrun}); end
  endtask

  task automatic test_frame_err();
    int rise;
    drive_frame(8'h3C, 1'b0, -1, FRAME_CYC, rise);
    model_frame(8'h3C, 1'b0, -1);
    Rx = 1'b0;
    repeat (3 * C) tick();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    checks++; if (rx_byte !== 8'hA5 || byte_valid !== 1'b0) begin errors++; $display("FAIL ferr_hold: byte=%h valid=%b want a5 0", rx_byte, byte_valid); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_break_no_restart: busy=%b want 1", rx_busy); end
    idle(4);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_release: busy=%b want 0", rx_busy); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    int rise;
    drive_frame(8'h11, 1'b1, -1, FRAME_CYC, rise); model_frame(8'h11, 1'b1, -1); idle(C);
    drive_frame(8'h22, 1'b1, -1, FRAME_CYC, rise); model_frame(8'h22, 1'b1, -1); idle(C);
    checks++; if (rx_byte !== 8'h22) begin errors++; $display("FAIL ovr_byte: got %h want 22", rx_byte); end
    checks++; if (overrun !== 1'b1 || byte_valid !== 1'b1) begin errors++; $display("FAIL ovr_set: ovr=%b valid=%b want 1 1", overrun, byte_valid); end
    pulse_clr();
    drive_frame(8'h33, 1'b1, LAT, FRAME_CYC, rise); model_frame(8'h33, 1'b1, LAT);
    checks++; if (overrun !== 1'b0 || byte_valid !== 1'b1) begin errors++; $display("FAIL ack_on_commit: ovr=%b valid=%b want 0 1", overrun, byte_valid); end
    checks++; if (rx_byte !== 8'h33) begin errors++; $display("FAIL ack_on_commit_byte: got %h want 33", rx_byte); end
    idle(C);
  endtask

  task automatic test_reset_mid_frame();
    int rise;
    drive_frame(8'h44, 1'b1, -1, FRAME_CYC, rise); model_frame(8'h44, 1'b1, -1); idle(C);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL pre_reset_ovr: got %b want 1", overrun); end
    // Stop in the middle of data bit 4.
    drive_frame(8'h96, 1'b1, -1, C + 4 * C + C / 2, rise);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy: got %b want 1", rx_busy); end
    reset = 1'b1;
    Rx    = 1'b1;
    tick();
    checks++; if ({rx_byte, byte_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_outputs: byte=%h valid=%b busy=%b ferr=%b ovr=%b want all 0",
                         rx_byte, byte_valid, rx_busy, frame_err, overrun);
    end
    reset = 1'b0;
    exp_byte = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    idle(2 * C);
    drive_frame(8'h5A, 1'b1, -1, FRAME_CYC, rise); model_frame(8'h5A, 1'b1, -1);
    checks++; if (rx_byte !== 8'h5A || byte_valid !== 1'b1) begin errors++; $display("FAIL after_reset_5a: byte=%h valid=%b want 5a 1", rx_byte, byte_valid); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL after_reset_flags: ferr=%b ovr=%b want 0 0", frame_err, overrun); end
  endtask

  task automatic test_back_to_back();
    int rise;
    pulse_ack();
    drive_frame(8'h00, 1'b1, LAT + 1, FRAME_CYC, rise); model_frame(8'h00, 1'b1, LAT + 1);
    checks++; if (rise !== 1 + LAT || rx_byte !== 8'h00) begin errors++; $display("FAIL b2b_first: rise=%0d byte=%h want %0d 00", rise, rx_byte, 1 + LAT); end
    drive_frame(8'hFF, 1'b1, LAT + 1, FRAME_CYC, rise); model_frame(8'hFF, 1'b1, LAT + 1);
    checks++; if (rise !== 1 + LAT || rx_byte !== 8'hFF) begin errors++; $display("FAIL b2b_second: rise=%0d byte=%h want %0d ff", rise, rx_byte, 1 + LAT); end
    checks++; if (overrun !== 1'b0 || byte_valid !== 1'b0) begin errors++; $display("FAIL b2b_flags: ovr=%b valid=%b want 0 0", overrun, byte_valid); end
    idle(C);
  endtask

  task automatic test_random();
    int rise;
    int ack_opts [4];
    ack_opts[0] = -1; ack_opts[1] = 5; ack_opts[2] = LAT; ack_opts[3] = LAT + 1;
    for (int n = 0; n < 24; n++) begin
      logic [DB-1:0] data;
      logic          stop;
      int            ack_k;
      int            gap;
      data  = DB'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      ack_k = ack_opts[$urandom_range(0, 3)];
      gap   = $urandom_range(stop ? 0 : 1, C);
      if ($urandom_range(0, 4) == 0) pulse_clr();
      drive_frame(data, stop, ack_k, FRAME_CYC, rise);
      model_frame(data, stop, ack_k);
      checks++; if (rx_byte !== exp_byte) begin errors++; $display("FAIL rnd%0d_byte: got %h want %h", n, rx_byte, exp_byte); end
      checks++; if (byte_valid !== exp_valid) begin errors++; $display("FAIL rnd%0d_valid: got %b want %b", n, byte_valid, exp_valid); end
      checks++; if (frame_err !== exp_ferr) begin errors++; $display("FAIL rnd%0d_ferr: got %b want %b", n, frame_err, exp_ferr); end
      checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL rnd%0d_ovr: got %b want %b", n, overrun, exp_ovr); end
      idle(gap);
    end
  endtask

  initial begin
    reset   = 1'b1;
    Rx      = 1'b1;
    rd_ack  = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
